instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid in 1, in_ready out 1. Request handshake; transfer when both high.
REQ-004 SHALL have ports: in_op in 4. Op class: 0 ADD, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 J, 7 LUI, 8 ORI, 9 LI (pseudo), 10-15 illegal.
REQ-005 SHALL have ports: in_rs, in_rt, in_rd in 5 each (register fields); in_imm in 32 (immediate or jump target).
REQ-006 SHALL have ports: out_valid out 1, out_ready in 1, out_word out 32, out_addr out 32. Encoded instruction and its byte address.
REQ-007 SHALL have ports: addr_load in 1, addr_value in 32 (set emit address); err out 1 (illegal-op pulse).

Function
REQ-008 SHALL encode R-type ADD as op 000000|rs|rt|rd|shamt 0|funct 100000.
REQ-009 SHALL encode ADDI/LW/SW/BEQ/BNE/ORI as opcode|rs|rt|in_imm[15:0]. Opcodes: 001000, 100011, 101011, 000100, 000101, 001101.
REQ-010 SHALL encode LUI as 001111|00000|rt|in_imm[15:0], and J as 000010|in_imm[25:0].
REQ-011 SHALL expand LI rt,imm32 as follows:
- imm[31:16]==0: single ORI rt,$0,imm[15:0].
- Otherwise, imm[15:0]==0: single LUI rt,imm[31:16].
- Otherwise: two words, LUI rt,imm[31:16] then ORI rt,rt,imm[15:0].
REQ-012 SHALL use FSM states IDLE, SECOND:
- IDLE->SECOND on accepting a two-word LI.
- SECOND->IDLE when the first word handshakes; the second word loads into the output register in that same cycle.
REQ-013 SHALL set in_ready = (state==IDLE) && (!out_valid || out_ready), with no combinational path from in_valid.
REQ-014 SHALL give latency of one cycle: a request accepted at edge N presents its first word with out_valid high after edge N.
REQ-015 SHALL hold out_word/out_addr stable while out_valid && !out_ready.
REQ-016 SHALL sustain one word per cycle with back-to-back single-word requests and out_ready held high.
REQ-017 SHALL maintain the address counter as follows:
- Increment by 4 on each output handshake.
- Wrap 0xFFFFFFFC->0x00000000.
- out_addr is the counter value captured when the word was loaded.
REQ-018 SHALL, when addr_load is high, set the counter to {addr_value[31:2],2'b00}. If a handshake occurs in the same cycle, the load wins, and the next loaded word gets addr_value.
REQ-019 SHALL handle illegal in_op as follows: the request is accepted, no word is produced, and err is high for exactly one cycle after acceptance.
REQ-020 SHALL ignore unused fields, e.g. rd for I-type, rs for J.

Reset
REQ-021 SHALL, on reset, force state IDLE, out_valid 0, out_word 0, out_addr 0, counter 0, err 0. in_ready is then 1 in the first cycle after reset.
REQ-022 SHALL, on reset during SECOND or with a pending word, discard all pending words and emit no partial LI.

Structure
REQ-023 SHALL place opcode constants (shared with the control decoder), the ADD funct code and the in_op class codes in a shared package.
REQ-024 SHALL implement field packing in one combinational sub-module instr_format (op class, fields, LI half select -> 32-bit word); the FSM, output register and counter SHALL reside in instr_encoder.

Verification
REQ-025 SHALL test ADD rd=3,rs=1,rt=2 after reset -> out_word 0x00221820, out_addr 0x00000000, one cycle latency.
REQ-026 SHALL test LI rt=9, imm 0x12345678 -> 0x3C091234 @0x0, then 0x35295678 @0x4; in_ready low until the first handshake. LI rt=9, imm 0x0000ABCD -> single 0x3409ABCD.
REQ-027 SHALL test ADDI rt=8,rs=0,imm=5; LW rt=4,rs=29,imm=8; J imm=0x100; BEQ rs=1,rt=2,imm=0xFFFF with out_ready always high -> 0x20080005, 0x8FA40008, 0x08000100, 0x1022FFFF at consecutive cycles, addresses 0x0/0x4/0x8/0xC.
REQ-028 SHALL test out_ready held low 3 cycles with a word pending -> word and address stable, in_ready low, no request lost.
REQ-029 SHALL test addr_load 0xFFFFFFFF, then a two-word LI -> addresses 0xFFFFFFFC then 0x00000000.
REQ-030 SHALL test in_op=12 -> accepted, err one-cycle pulse, no out_valid. Reset asserted in SECOND -> no ORI word emitted afterwards.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared constants for the instruction encoder: request op classes, MIPS opcodes
// and funct codes (also consumed by the control decoder), and encoder FSM states.
package instr_encoder_pkg;

    localparam logic [3:0] CLS_ADD  = 4'd0;
    localparam logic [3:0] CLS_ADDI = 4'd1;
    localparam logic [3:0] CLS_LW   = 4'd2;
    localparam logic [3:0] CLS_SW   = 4'd3;
    localparam logic [3:0] CLS_BEQ  = 4'd4;
    localparam logic [3:0] CLS_BNE  = 4'd5;
    localparam logic [3:0] CLS_J    = 4'd6;
    localparam logic [3:0] CLS_LUI  = 4'd7;
    localparam logic [3:0] CLS_ORI  = 4'd8;
    localparam logic [3:0] CLS_LI   = 4'd9;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_ORI   = 6'b001101;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= CLS_LI;
    endfunction

    // LI needs LUI+ORI only when both halves of the immediate are non-zero.
    function automatic logic li_needs_two(input logic [31:0] imm);
        return (imm[31:16] != 16'd0) && (imm[15:0] != 16'd0);
    endfunction

endpackage

// File: rtl/instr_format.sv
// Combinational field packing: op class plus register/immediate fields -> one
// 32-bit MIPS word. li_second selects the trailing ORI half of a two-word LI.
module instr_format
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    input  logic        li_second,
    output logic [31:0] word
);

    always_comb begin
        word = 32'd0;
        case (op)
            CLS_ADD:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADD};
            CLS_ADDI: word = {OPC_ADDI, rs, rt, imm[15:0]};
            CLS_LW:   word = {OPC_LW,   rs, rt, imm[15:0]};
            CLS_SW:   word = {OPC_SW,   rs, rt, imm[15:0]};
            CLS_BEQ:  word = {OPC_BEQ,  rs, rt, imm[15:0]};
            CLS_BNE:  word = {OPC_BNE,  rs, rt, imm[15:0]};
            CLS_ORI:  word = {OPC_ORI,  rs, rt, imm[15:0]};
            CLS_LUI:  word = {OPC_LUI,  5'd0, rt, imm[15:0]};
            CLS_J:    word = {OPC_J,    imm[25:0]};
            CLS_LI: begin
                // Single-word forms pick whichever half carries the value.
                if (li_second)
                    word = {OPC_ORI, rt, rt, imm[15:0]};
                else if (imm[31:16] == 16'd0)
                    word = {OPC_ORI, 5'd0, rt, imm[15:0]};
                else
                    word = {OPC_LUI, 5'd0, rt, imm[31:16]};
            end
            default:  word = 32'd0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts op requests, emits encoded words with their byte
// address through a one-deep output register, expanding LI into one or two words.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    input  logic        addr_load,
    input  logic [31:0] addr_value,
    output logic        err
);

    state_e      state;
    state_e      state_next;
    logic        accept;
    logic        fire;
    logic        load;
    logic        legal;
    logic        two_word;
    logic [31:0] counter;
    logic [31:0] counter_next;

    logic [3:0]  fmt_op;
    logic [4:0]  fmt_rs;
    logic [4:0]  fmt_rt;
    logic [4:0]  fmt_rd;
    logic [31:0] fmt_imm;
    logic        fmt_second;
    logic [31:0] fmt_word;

    logic [4:0]  li_rt;
    logic [15:0] li_lo;

    assign fire     = out_valid && out_ready;
    assign legal    = op_is_legal(in_op);
    assign two_word = (in_op == CLS_LI) && li_needs_two(in_imm);

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept && two_word) state_next = ST_SECOND;
            ST_SECOND: if (fire) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // In SECOND the output register reloads with the ORI half as the LUI leaves.
    always_comb begin
        in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        load     = (state == ST_IDLE) ? (accept && legal) : fire;
    end

    always_comb begin
        fmt_second = (state == ST_SECOND);
        if (fmt_second) begin
            fmt_op  = CLS_LI;
            fmt_rs  = li_rt;
            fmt_rt  = li_rt;
            fmt_rd  = 5'd0;
            fmt_imm = {16'd0, li_lo};
        end else begin
            fmt_op  = in_op;
            fmt_rs  = in_rs;
            fmt_rt  = in_rt;
            fmt_rd  = in_rd;
            fmt_imm = in_imm;
        end
    end

    instr_format u_format (
        .op        (fmt_op),
        .rs        (fmt_rs),
        .rt        (fmt_rt),
        .rd        (fmt_rd),
        .imm       (fmt_imm),
        .li_second (fmt_second),
        .word      (fmt_word)
    );

    // counter holds the address the next loaded word will carry.
    always_comb begin
        if (addr_load)
            counter_next = {addr_value[31:2], 2'b00};
        else if (fire)
            counter_next = counter + 32'd4;
        else
            counter_next = counter;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_word  <= 32'd0;
            out_addr  <= 32'd0;
            counter   <= 32'd0;
            err       <= 1'b0;
        end else begin
            counter <= counter_next;
            err     <= accept && !legal;
            if (load) begin
                out_valid <= 1'b1;
                out_word  <= fmt_word;
                out_addr  <= counter_next;
            end else if (fire) begin
                out_valid <= 1'b0;
            end
        end
    end

    // LI second-half operands; only meaningful while in SECOND.
    always_ff @(posedge clk) begin
        if (accept && two_word) begin
            li_rt <= in_rt;
            li_lo <= in_imm[15:0];
        end
    end

endmodule
